// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared types and constants for the data-memory arbiter.
//   owner_e   : which requester currently holds the memory (IDLE/CORE/NIC)
//   PORT_*    : requester index used in grant vectors and the read-return tag
//   DMEM_*    : data memory geometry (256 x 64)
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 64;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_NIC  = 1'b1;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_CORE = 2'b01,
    OWN_NIC  = 2'b10
  } owner_e;

  function automatic owner_e port2own(input logic port);
    return (port == PORT_NIC) ? OWN_NIC : OWN_CORE;
  endfunction

endpackage

// File: rtl/dmem_arbiter_arb.sv
// -----------------------------------------------------------------------------
// rr_burst_arb
// Two-way round-robin arbiter with a bounded burst. The current owner keeps
// the grant while both sides request until it has held MAX_BURST consecutive
// cycles; a lone requester is always granted.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   req_i   : request vector, bit PORT_CORE / bit PORT_NIC
//   gnt_o   : one-hot grant (combinational from req_i and registered state)
// -----------------------------------------------------------------------------
module rr_burst_arb
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  owner_e             owner_q, owner_d;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic               last_q,  last_d;
  logic               hold_ok;
  logic               gnt_port;

  always_comb begin
    gnt_o    = '0;
    owner_d  = owner_q;
    burst_d  = burst_q;
    last_d   = last_q;
    gnt_port = PORT_CORE;
    hold_ok  = (burst_q < CNT_W'(MAX_BURST));

    case (req_i)
      2'b01:   gnt_port = PORT_CORE;
      2'b10:   gnt_port = PORT_NIC;
      2'b11: begin
        if (owner_q == OWN_CORE && hold_ok)     gnt_port = PORT_CORE;
        else if (owner_q == OWN_NIC && hold_ok) gnt_port = PORT_NIC;
        else                                    gnt_port = ~last_q;
      end
      default: gnt_port = PORT_CORE;
    endcase

    if (req_i == 2'b00) begin
      owner_d = OWN_IDLE;
      burst_d = '0;
    end else begin
      gnt_o[gnt_port] = 1'b1;
      // Counter saturates at MAX_BURST so a long solo run hands over at once.
      if (owner_q == port2own(gnt_port))
        burst_d = hold_ok ? burst_q + 1'b1 : burst_q;
      else
        burst_d = CNT_W'(1);
      owner_d = port2own(gnt_port);
      last_d  = gnt_port;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= OWN_IDLE;
      burst_q <= '0;
      last_q  <= PORT_NIC;   // core wins the first tie
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-ported 256x64 data memory between the core (port 0) and
// the NIC/host DMA (port 1). One access per cycle, round-robin with burst.
// Read data returns one cycle after the grant, tagged to the requester.
// Ports:
//   Clock, Reset                        : clock, sync active-high reset
//   Core_Req/WrEn/Addr/WrData           : core request
//   Core_Gnt, Core_Stall, Core_RdValid  : core grant, pipeline hold, read valid
//   Nic_Req/WrEn/Addr/WrData            : NIC request
//   Nic_Gnt, Nic_RdValid                : NIC grant, read valid
//   Rd_Data                             : memory read data to both requesters
//   Mem_En/WrEn/Addr/Data_Out           : memory macro command
//   Mem_Data_In                         : memory read data (cycle after read)
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Core_Req,
  input  logic               Core_WrEn,
  input  logic [DMEM_AW-1:0] Core_Addr,
  input  logic [DMEM_DW-1:0] Core_WrData,
  output logic               Core_Gnt,
  output logic               Core_Stall,
  output logic               Core_RdValid,
  input  logic               Nic_Req,
  input  logic               Nic_WrEn,
  input  logic [DMEM_AW-1:0] Nic_Addr,
  input  logic [DMEM_DW-1:0] Nic_WrData,
  output logic               Nic_Gnt,
  output logic               Nic_RdValid,
  output logic [DMEM_DW-1:0] Rd_Data,
  output logic               Mem_En,
  output logic               Mem_WrEn,
  output logic [DMEM_AW-1:0] Mem_Addr,
  output logic [DMEM_DW-1:0] Mem_Data_Out,
  input  logic [DMEM_DW-1:0] Mem_Data_In
);

  logic [1:0] req, gnt;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_id_q,   rd_id_d;

  assign req[PORT_CORE] = Core_Req;
  assign req[PORT_NIC]  = Nic_Req;

  rr_burst_arb #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_arb (
    .clk_i (Clock),
    .rst_i (Reset),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign Core_Gnt   = gnt[PORT_CORE];
  assign Nic_Gnt    = gnt[PORT_NIC];
  assign Core_Stall = Core_Req & ~Core_Gnt;

  always_comb begin
    Mem_En       = Core_Gnt | Nic_Gnt;
    Mem_WrEn     = 1'b0;
    Mem_Addr     = '0;
    Mem_Data_Out = '0;
    if (Core_Gnt) begin
      Mem_WrEn     = Core_WrEn;
      Mem_Addr     = Core_Addr;
      Mem_Data_Out = Core_WrData;
    end else if (Nic_Gnt) begin
      Mem_WrEn     = Nic_WrEn;
      Mem_Addr     = Nic_Addr;
      Mem_Data_Out = Nic_WrData;
    end
  end

  // Read-return tag: follows the memory's one-cycle read latency.
  assign rd_pend_d = Mem_En & ~Mem_WrEn;
  assign rd_id_d   = Nic_Gnt ? PORT_NIC : PORT_CORE;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_pend_q <= 1'b0;
      rd_id_q   <= PORT_CORE;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  assign Core_RdValid = rd_pend_q & (rd_id_q == PORT_CORE);
  assign Nic_RdValid  = rd_pend_q & (rd_id_q == PORT_NIC);
  assign Rd_Data      = Mem_Data_In;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int MAXB = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Core_Req, Core_WrEn, Nic_Req, Nic_WrEn;
  logic [7:0]  Core_Addr, Nic_Addr, Mem_Addr;
  logic [63:0] Core_WrData, Nic_WrData, Rd_Data, Mem_Data_Out, Mem_Data_In;
  logic        Core_Gnt, Core_Stall, Core_RdValid, Nic_Gnt, Nic_RdValid;
  logic        Mem_En, Mem_WrEn;

  dmem_arbiter #(.MAX_BURST(MAXB), .CNT_W(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .Core_Req(Core_Req), .Core_WrEn(Core_WrEn), .Core_Addr(Core_Addr),
    .Core_WrData(Core_WrData), .Core_Gnt(Core_Gnt), .Core_Stall(Core_Stall),
    .Core_RdValid(Core_RdValid),
    .Nic_Req(Nic_Req), .Nic_WrEn(Nic_WrEn), .Nic_Addr(Nic_Addr),
    .Nic_WrData(Nic_WrData), .Nic_Gnt(Nic_Gnt), .Nic_RdValid(Nic_RdValid),
    .Rd_Data(Rd_Data), .Mem_En(Mem_En), .Mem_WrEn(Mem_WrEn),
    .Mem_Addr(Mem_Addr), .Mem_Data_Out(Mem_Data_Out), .Mem_Data_In(Mem_Data_In)
  );

  always #5 Clock = ~Clock;

  function automatic logic [63:0] init_word(input logic [7:0] a);
    return (a == 8'h10) ? 64'hDEAD_BEEF_0000_0001 : {56'hA5A5_0000_0000_00, a};
  endfunction

  // Memory macro: synchronous read, one-cycle latency.
  logic [63:0] mem [256];
  bit   [255:0] mem_vld;
  always @(posedge Clock) begin
    if (Mem_En) begin
      if (Mem_WrEn) begin
        mem[Mem_Addr]     <= Mem_Data_Out;
        mem_vld[Mem_Addr] <= 1'b1;
      end else begin
        Mem_Data_In <= mem_vld[Mem_Addr] ? mem[Mem_Addr] : init_word(Mem_Addr);
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: grant history, last granted port, reference memory.
  int          hist[$];
  int          last_gnt = -1;
  int          exp_rv   = -1;
  logic [63:0] exp_rd;
  logic [63:0] ref_mem [256];
  bit   [255:0] ref_vld;
  bit          model_chk = 0;

  logic        o_cg, o_ng, o_stall, o_men, o_mwe, o_crv, o_nrv;
  logic [7:0]  o_maddr;
  logic [63:0] o_mdo, o_rd;

  function automatic int model_grant();
    int p, run;
    if (!Core_Req && !Nic_Req) return -1;
    if (Core_Req && !Nic_Req)  return 0;
    if (!Core_Req)             return 1;
    if (hist.size() > 0 && hist[$] >= 0) begin
      p = hist[$];
      run = 0;
      for (int i = hist.size() - 1; i >= 0 && hist[i] == p; i--) run++;
      if (run < MAXB) return p;
    end
    return (last_gnt == 0) ? 1 : 0;
  endfunction

  task automatic step();
    int g;
    logic        we;
    logic [7:0]  a;
    logic [63:0] d;
    @(negedge Clock);
    o_cg = Core_Gnt;  o_ng = Nic_Gnt;  o_stall = Core_Stall;
    o_men = Mem_En;   o_mwe = Mem_WrEn; o_maddr = Mem_Addr; o_mdo = Mem_Data_Out;
    o_crv = Core_RdValid; o_nrv = Nic_RdValid; o_rd = Rd_Data;
    g  = model_grant();
    we = (g == 0) ? Core_WrEn   : (g == 1) ? Nic_WrEn   : 1'b0;
    a  = (g == 0) ? Core_Addr   : (g == 1) ? Nic_Addr   : 8'h0;
    d  = (g == 0) ? Core_WrData : (g == 1) ? Nic_WrData : 64'h0;
    if (model_chk && !Reset) begin
      chk("m_core_gnt", {63'h0, o_cg}, {63'h0, g == 0});
      chk("m_nic_gnt",  {63'h0, o_ng}, {63'h0, g == 1});
      chk("m_stall",    {63'h0, o_stall}, {63'h0, Core_Req && g != 0});
      chk("m_mem_cmd",  {54'h0, o_men, o_mwe, o_maddr}, {54'h0, g >= 0, we, a});
      chk("m_mem_wdat", o_mdo, d);
      chk("m_core_rv",  {63'h0, o_crv}, {63'h0, exp_rv == 0});
      chk("m_nic_rv",   {63'h0, o_nrv}, {63'h0, exp_rv == 1});
      if (exp_rv >= 0) chk("m_rd_data", o_rd, exp_rd);
    end
    if (Reset) begin
      hist.delete();
      last_gnt = -1;
      exp_rv   = -1;
    end else begin
      hist.push_back(g);
      if (hist.size() > 16) void'(hist.pop_front());
      exp_rv = -1;
      if (g >= 0) begin
        last_gnt = g;
        if (we) begin
          ref_mem[a] = d;
          ref_vld[a] = 1'b1;
        end else begin
          exp_rv = g;
          exp_rd = ref_vld[a] ? ref_mem[a] : init_word(a);
        end
      end
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [63:0] cd,
                       input logic nr, input logic nw, input logic [7:0] na, input logic [63:0] nd);
    Core_Req = cr; Core_WrEn = cw; Core_Addr = ca; Core_WrData = cd;
    Nic_Req  = nr; Nic_WrEn  = nw; Nic_Addr  = na; Nic_WrData  = nd;
  endtask

  task automatic do_reset();
    drive(0, 0, 8'h0, 64'h0, 0, 0, 8'h0, 64'h0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  typedef struct {
    logic rst, cr, cw; logic [7:0] ca; logic [63:0] cd;
    logic nr, nw; logic [7:0] na; logic [63:0] nd;
    logic ecg, eng, est, emen, emwe; logic [7:0] emaddr;
    logic ecrv, enrv, chkd; logic [63:0] erd;
  } vec_t;
  vec_t vq[$];

  task automatic add_vec(input logic rst, input logic cr, input logic cw, input logic [7:0] ca,
                         input logic [63:0] cd, input logic nr, input logic nw, input logic [7:0] na,
                         input logic [63:0] nd, input logic ecg, input logic eng, input logic est,
                         input logic emen, input logic emwe, input logic [7:0] emaddr,
                         input logic ecrv, input logic enrv, input logic chkd, input logic [63:0] erd);
    vec_t v;
    v.rst = rst; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.nr = nr; v.nw = nw; v.na = na; v.nd = nd;
    v.ecg = ecg; v.eng = eng; v.est = est; v.emen = emen; v.emwe = emwe; v.emaddr = emaddr;
    v.ecrv = ecrv; v.enrv = enrv; v.chkd = chkd; v.erd = erd;
    vq.push_back(v);
  endtask

  string pat;
  bit    c_pend, c_we, n_pend, n_we;
  logic [7:0]  c_addr, n_addr;
  logic [63:0] c_wd, n_wd;
  int    dens;

  initial begin
    Reset = 1'b1;
    drive(0, 0, 8'h0, 64'h0, 0, 0, 8'h0, 64'h0);
    step();
    step();
    Reset = 1'b0;
    model_chk = 1;

    //        rst cr cw ca     cd      nr nw na     nd    cg ng st men mwe maddr  crv nrv chkd rd
    add_vec(0, 0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 64'h0);
    add_vec(0, 1, 0, 8'h10, 64'h0, 0, 0, 8'h00, 64'h0, 1, 0, 0, 1, 0, 8'h10, 0, 0, 0, 64'h0);
    add_vec(0, 0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1, 64'hDEAD_BEEF_0000_0001);
    add_vec(1, 0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 64'h0);
    add_vec(0, 1, 1, 8'h20, 64'h5, 1, 0, 8'h20, 64'h0, 1, 0, 0, 1, 1, 8'h20, 0, 0, 0, 64'h0);
    add_vec(0, 0, 0, 8'h00, 64'h0, 1, 0, 8'h20, 64'h0, 0, 1, 0, 1, 0, 8'h20, 0, 0, 0, 64'h0);
    add_vec(0, 0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 64'h5);
    add_vec(0, 1, 0, 8'h01, 64'h0, 0, 0, 8'h00, 64'h0, 1, 0, 0, 1, 0, 8'h01, 0, 0, 0, 64'h0);
    add_vec(0, 0, 0, 8'h00, 64'h0, 1, 0, 8'h02, 64'h0, 0, 1, 0, 1, 0, 8'h02, 1, 0, 1, 64'hA5A5_0000_0000_0001);
    add_vec(0, 1, 0, 8'h03, 64'h0, 0, 0, 8'h00, 64'h0, 1, 0, 0, 1, 0, 8'h03, 0, 1, 1, 64'hA5A5_0000_0000_0002);
    add_vec(0, 0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1, 64'hA5A5_0000_0000_0003);
    add_vec(0, 1, 0, 8'h04, 64'h0, 1, 0, 8'h05, 64'h0, 0, 1, 1, 1, 0, 8'h05, 0, 0, 0, 64'h0);
    add_vec(0, 0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 64'hA5A5_0000_0000_0005);

    foreach (vq[i]) begin
      Reset = vq[i].rst;
      drive(vq[i].cr, vq[i].cw, vq[i].ca, vq[i].cd, vq[i].nr, vq[i].nw, vq[i].na, vq[i].nd);
      step();
      Reset = 1'b0;
      if (!vq[i].rst) begin
        chk($sformatf("v%0d_core_gnt", i), {63'h0, o_cg}, {63'h0, vq[i].ecg});
        chk($sformatf("v%0d_nic_gnt", i),  {63'h0, o_ng}, {63'h0, vq[i].eng});
        chk($sformatf("v%0d_stall", i),    {63'h0, o_stall}, {63'h0, vq[i].est});
        chk($sformatf("v%0d_mem_cmd", i),  {54'h0, o_men, o_mwe, o_maddr},
                                           {54'h0, vq[i].emen, vq[i].emwe, vq[i].emaddr});
        chk($sformatf("v%0d_rdvalid", i),  {62'h0, o_crv, o_nrv}, {62'h0, vq[i].ecrv, vq[i].enrv});
        if (vq[i].chkd) chk($sformatf("v%0d_rd_data", i), o_rd, vq[i].erd);
      end
    end

    // Both requesting from reset: bursts of MAXB alternate, core first.
    do_reset();
    pat = "CCCCNNNNCC";
    drive(1, 0, 8'h30, 64'h0, 1, 0, 8'h31, 64'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("burst%0d_core_gnt", i), {63'h0, o_cg}, {63'h0, pat[i] == "C"});
      chk($sformatf("burst%0d_nic_gnt", i),  {63'h0, o_ng}, {63'h0, pat[i] == "N"});
      chk($sformatf("burst%0d_stall", i),    {63'h0, o_stall}, {63'h0, pat[i] == "N"});
    end

    // NIC alone for 10 cycles, then core joins: saturated NIC hands over at once.
    do_reset();
    drive(0, 0, 8'h00, 64'h0, 1, 0, 8'h40, 64'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("solo%0d_nic_gnt", i), {62'h0, o_cg, o_ng}, 64'h1);
    end
    drive(1, 0, 8'h41, 64'h0, 1, 0, 8'h40, 64'h0);
    step();
    chk("handover_gnt", {62'h0, o_cg, o_ng}, 64'h2);
    step();
    chk("handover_hold", {62'h0, o_cg, o_ng}, 64'h2);

    // Reset while a core read is being granted: return discarded, tie to core.
    do_reset();
    drive(1, 0, 8'h10, 64'h0, 0, 0, 8'h00, 64'h0);
    for (int i = 0; i < 3; i++) step();
    Reset = 1'b1;
    step();
    chk("rstmid_gnt", {63'h0, o_cg}, 64'h1);
    Reset = 1'b0;
    drive(0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0);
    step();
    chk("rstmid_rv_t1", {62'h0, o_crv, o_nrv}, 64'h0);
    drive(1, 0, 8'h11, 64'h0, 1, 0, 8'h12, 64'h0);
    step();
    chk("rstmid_rv_t2", {62'h0, o_crv, o_nrv}, 64'h0);
    chk("rstmid_tie", {62'h0, o_cg, o_ng}, 64'h2);

    // Randomised traffic; requests held until granted.
    do_reset();
    c_pend = 0; n_pend = 0;
    dens = 60;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      if (cyc % 100 == 0) dens = int'($urandom_range(20, 100));
      if (!c_pend && $urandom_range(0, 99) < dens) begin
        c_pend = 1; c_we = 1'($urandom); c_addr = 8'($urandom_range(0, 15));
        c_wd = {$urandom, $urandom};
      end
      if (!n_pend && $urandom_range(0, 99) < dens) begin
        n_pend = 1; n_we = 1'($urandom); n_addr = 8'($urandom_range(0, 15));
        n_wd = {$urandom, $urandom};
      end
      drive(c_pend, c_we, c_addr, c_wd, n_pend, n_we, n_addr, n_wd);
      step();
      if (o_cg) c_pend = 0;
      if (o_ng) n_pend = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
